// File: rtl/noc_input_unit.sv
// Router input port: flit FIFO, XY route of the front head flit, and a wormhole-locked crossbar request.
// Optional packet counter output pkt_cnt_o is enabled with `define NOC_IU_PERF_EN.
module noc_input_unit #(
    parameter int DATA_W = 32,
    parameter int CW     = 4,
    parameter int DEPTH  = 4,
    parameter int PORT_N = 5,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flit_valid_i,
    input  logic [DATA_W-1:0] flit_i,
    output logic              ready_o,
    output logic              req_o,
    output logic [PORT_N-1:0] port_o,
    input  logic              grt_i,
    output logic              flit_valid_o,
    output logic [DATA_W-1:0] flit_o,
    output logic              err_o
`ifdef NOC_IU_PERF_EN
    ,
    output logic [15:0]       pkt_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] MY_XC = CW'(MY_X);
    localparam logic [CW-1:0] MY_YC = CW'(MY_Y);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic [PORT_N-1:0] port_q, port_d;
    logic              err_q, err_d;

    logic              empty, full, push, pop;
    logic [DATA_W-1:0] front;
    logic [1:0]        front_type;
    logic [CW-1:0]     dest_x, dest_y;
    logic [PORT_N-1:0] route_oh;

    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == (AW+1)'(DEPTH));
    assign push       = flit_valid_i & ~full;
    assign front      = mem_q[rd_ptr_q];
    assign front_type = front[DATA_W-1 -: 2];
    assign dest_x     = front[DATA_W-3 -: CW];
    assign dest_y     = front[DATA_W-3-CW -: CW];

    // Dimension-ordered: resolve X fully before Y.
    always_comb begin
        route_oh = '0;
        if (dest_x > MY_XC)      route_oh[2] = 1'b1;
        else if (dest_x < MY_XC) route_oh[4] = 1'b1;
        else if (dest_y > MY_YC) route_oh[1] = 1'b1;
        else if (dest_y < MY_YC) route_oh[3] = 1'b1;
        else                     route_oh[0] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        err_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (front_type[0]) begin
                        port_d  = route_oh;
                        state_d = ACTIVE;
                    end else begin
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (!empty && grt_i) begin
                    pop = 1'b1;
                    if (front_type[1]) begin
                        state_d = IDLE;
                        port_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (push ? (AW+1)'(1) : '0) - (pop ? (AW+1)'(1) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            port_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= flit_i;
    end

    assign ready_o      = ~full;
    assign req_o        = (state_q == ACTIVE);
    assign port_o       = port_q;
    assign flit_valid_o = (state_q == ACTIVE) & ~empty;
    assign flit_o       = front;
    assign err_o        = err_q;

`ifdef NOC_IU_PERF_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (state_q == ACTIVE && pop && front_type[1]) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pkt_cnt_q <= '0;
        else        pkt_cnt_q <= pkt_cnt_d;
    end

    assign pkt_cnt_o = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_noc_input_unit.sv
// Bench for noc_input_unit: directed latency/boundary cases plus randomized packet traffic
// checked against a stream-level scoreboard (flit order, route per packet, drops, packet count).
module tb_noc_input_unit;
    localparam int DW = 32, CW = 4, DEPTH = 4, PN = 5, MX = 1, MY = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flit_valid_i = 1'b0;
    logic [DW-1:0] flit_i = '0;
    logic          grt_i = 1'b0;
    logic          ready_o, req_o, flit_valid_o, err_o;
    logic [PN-1:0] port_o;
    logic [DW-1:0] flit_o;
`ifdef NOC_IU_PERF_EN
    logic [15:0]   pkt_cnt_o;
`endif

    noc_input_unit #(.DATA_W(DW), .CW(CW), .DEPTH(DEPTH), .PORT_N(PN), .MY_X(MX), .MY_Y(MY)) dut (
        .clk(clk), .rst_n(rst_n), .flit_valid_i(flit_valid_i), .flit_i(flit_i),
        .ready_o(ready_o), .req_o(req_o), .port_o(port_o), .grt_i(grt_i),
        .flit_valid_o(flit_valid_o), .flit_o(flit_o), .err_o(err_o)
`ifdef NOC_IU_PERF_EN
        , .pkt_cnt_o(pkt_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Stream-level reference: which flits must leave, through which port, and how many drops.
    logic [DW-1:0] exp_q[$];
    logic [PN-1:0] exp_port_q[$];
    logic [DW-1:0] stim_q[$];
    bit            in_pkt;
    logic [PN-1:0] cur_route;
    int            exp_err, seen_err, exp_pkts;
    logic          prev_req;
    logic [PN-1:0] prev_port;
    bit            accepted;

    localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int x, input int y);
        logic [3:0] xb, yb;
        logic [21:0] pay;
        xb  = 4'(x);
        yb  = 4'(y);
        pay = 22'($urandom);
        return {t, xb, yb, pay};
    endfunction

    function automatic logic [PN-1:0] route_of(input logic [DW-1:0] f);
        int x, y, idx;
        x = int'(f[29:26]);
        y = int'(f[25:22]);
        if (x > MX)      idx = 2;
        else if (x < MX) idx = 4;
        else if (y > MY) idx = 1;
        else if (y < MY) idx = 3;
        else             idx = 0;
        return PN'(1 << idx);
    endfunction

    task automatic model_push(input logic [DW-1:0] f);
        if (f[30]) begin
            cur_route = route_of(f);
            in_pkt    = !f[31];
            exp_q.push_back(f);
            exp_port_q.push_back(cur_route);
        end else if (!in_pkt) begin
            exp_err++;
        end else begin
            exp_q.push_back(f);
            exp_port_q.push_back(cur_route);
            if (f[31]) in_pkt = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_port_q.delete();
        in_pkt    = 0;
        cur_route = '0;
        exp_err   = seen_err;
        exp_pkts  = 0;
        prev_req  = 1'b0;
        prev_port = '0;
    endtask

    // Called at a negedge with inputs already set; scores this cycle, then advances one cycle.
    task automatic tick();
        logic [DW-1:0] ef;
        accepted = flit_valid_i && ready_o;
        if (accepted) model_push(flit_i);
        if (flit_valid_o && grt_i) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 64'(flit_valid_o), 64'd0);
            end else begin
                ef = exp_q.pop_front();
                check("flit", 64'(flit_o), 64'(ef));
                check("port", 64'(port_o), 64'(exp_port_q.pop_front()));
                if (ef[31]) exp_pkts++;
            end
        end
        if (!req_o) check("port_idle", 64'(port_o), 64'd0);
        if (req_o && prev_req) check("port_stable", 64'(port_o), 64'(prev_port));
        if (req_o) check("port_onehot", 64'($onehot(port_o)), 64'd1);
        prev_req  = req_o;
        prev_port = port_o;
        @(negedge clk);
        if (err_o) seen_err++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flit_valid_i = 1'b0;
        grt_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_stream(input int budget, input int grt_pct, input int vld_pct);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || req_o) && n < budget) begin
            flit_valid_i = (stim_q.size() != 0) && ($urandom_range(0, 99) < vld_pct);
            flit_i       = (stim_q.size() != 0) ? stim_q[0] : '0;
            grt_i        = ($urandom_range(0, 99) < grt_pct);
            tick();
            if (accepted) void'(stim_q.pop_front());
            n++;
        end
        if (n >= budget) check("stream_timeout", 64'(n), 64'(budget - 1));
        flit_valid_i = 1'b0;
        grt_i = 1'b1;
        repeat (4) tick();
        grt_i = 1'b0;
    endtask

    initial begin
        int req_cycles;
        seen_err = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_port", 64'(port_o), 64'd0);
        check("rst_fvo", 64'(flit_valid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
`ifdef NOC_IU_PERF_EN
        check("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
`endif

        // Single HEAD_TAIL eastbound: req one cycle after the push, pop on the next edge.
        grt_i = 1'b1;
        flit_valid_i = 1'b1;
        flit_i = mk(T_HT, 3, 1);
        tick();
        flit_valid_i = 1'b0;
        check("t1_req_after_push", 64'(req_o), 64'd0);
        tick();
        check("t1_req", 64'(req_o), 64'd1);
        check("t1_port", 64'(port_o), 64'b00100);
        check("t1_fvo", 64'(flit_valid_o), 64'd1);
        tick();
        check("t1_req_drop", 64'(req_o), 64'd0);
        check("t1_fvo_drop", 64'(flit_valid_o), 64'd0);

        // Four-flit packet southbound under continuous grant: lock held exactly 4 cycles.
        stim_q.push_back(mk(T_HEAD, 1, 0));
        stim_q.push_back(mk(T_BODY, 0, 0));
        stim_q.push_back(mk(T_BODY, 0, 0));
        stim_q.push_back(mk(T_TAIL, 0, 0));
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            flit_valid_i = (stim_q.size() != 0);
            flit_i = (stim_q.size() != 0) ? stim_q[0] : '0;
            tick();
            if (accepted) void'(stim_q.pop_front());
            if (req_o) begin
                req_cycles++;
                check("t2_port", 64'(port_o), 64'b01000);
            end
        end
        check("t2_req_cycles", 64'(req_cycles), 64'd4);
        check("t2_drained", 64'(exp_q.size()), 64'd0);

        // Fill with grant low; a blocked push while full (even when popping) must not be taken.
        grt_i = 1'b0;
        stim_q.push_back(mk(T_HEAD, 1, 1));
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(T_BODY, 0, 0));
        stim_q.push_back(mk(T_TAIL, 0, 0));
        for (int i = 0; i < 4; i++) begin
            flit_valid_i = 1'b1;
            flit_i = stim_q[0];
            tick();
            if (accepted) void'(stim_q.pop_front());
        end
        check("t3_full", 64'(ready_o), 64'd0);
        check("t3_req", 64'(req_o), 64'd1);
        check("t3_port_local", 64'(port_o), 64'b00001);
        flit_i = stim_q[0];
        tick();
        if (accepted) void'(stim_q.pop_front());
        check("t3_still_full", 64'(ready_o), 64'd0);
        grt_i = 1'b1;
        tick();
        if (accepted) void'(stim_q.pop_front());
        check("t3_ready_after_pop", 64'(ready_o), 64'd1);
        check("t3_stim_left", 64'(stim_q.size()), 64'd2);
        grt_i = 1'b0;
        run_stream(200, 100, 100);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // Stray BODY in IDLE: dropped with a single err pulse, then a westbound head.
        flit_valid_i = 1'b1;
        flit_i = mk(T_BODY, 2, 2);
        tick();
        flit_valid_i = 1'b0;
        check("t4_err_early", 64'(err_o), 64'd0);
        tick();
        check("t4_err_pulse", 64'(err_o), 64'd1);
        check("t4_req", 64'(req_o), 64'd0);
        tick();
        check("t4_err_single", 64'(err_o), 64'd0);
        check("t4_req_low", 64'(req_o), 64'd0);
        grt_i = 1'b1;
        flit_valid_i = 1'b1;
        flit_i = mk(T_HT, 0, 1);
        tick();
        flit_valid_i = 1'b0;
        tick();
        check("t4_west", 64'(port_o), 64'b10000);
        tick();
        check("t4_err_total", 64'(seen_err), 64'(exp_err));

        // Gap mid-packet: lock stays, nothing presented; tail not bypassed.
        flit_valid_i = 1'b1;
        flit_i = mk(T_HEAD, 1, 2);
        tick();
        flit_valid_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t5_gap_req", 64'(req_o), 64'd1);
            check("t5_gap_fvo", 64'(flit_valid_o), 64'd0);
            check("t5_gap_port", 64'(port_o), 64'b00010);
            if (i < 2) tick();
        end
        flit_valid_i = 1'b1;
        flit_i = mk(T_TAIL, 0, 0);
        tick();
        flit_valid_i = 1'b0;
        check("t5_tail_visible", 64'(flit_valid_o), 64'd1);
        tick();
        check("t5_req_drop", 64'(req_o), 64'd0);

        // Asynchronous reset mid-packet.
        grt_i = 1'b0;
        flit_valid_i = 1'b1;
        flit_i = mk(T_HEAD, 2, 2);
        tick();
        flit_i = mk(T_BODY, 0, 0);
        tick();
        flit_valid_i = 1'b0;
        check("t6_active", 64'(req_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 64'(req_o), 64'd0);
        check("t6_rst_port", 64'(port_o), 64'd0);
        check("t6_rst_fvo", 64'(flit_valid_o), 64'd0);
        check("t6_rst_err", 64'(err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("t6_ready", 64'(ready_o), 64'd1);
        tick();
        check("t6_no_stale", 64'(req_o), 64'd0);
`ifdef NOC_IU_PERF_EN
        check("t6_pkt_cnt_rst", 64'(pkt_cnt_o), 64'd0);
        stim_q.push_back(mk(T_HT, 0, 0));
        stim_q.push_back(mk(T_HEAD, 2, 0));
        stim_q.push_back(mk(T_TAIL, 0, 0));
        stim_q.push_back(mk(T_BODY, 0, 0));
        stim_q.push_back(mk(T_HEAD, 1, 3));
        stim_q.push_back(mk(T_BODY, 0, 0));
        stim_q.push_back(mk(T_TAIL, 0, 0));
        run_stream(200, 100, 100);
        check("t6_pkt_cnt", 64'(pkt_cnt_o), 64'd3);
`endif

        // Randomized traffic: well-formed packets with occasional stray non-head flits.
        for (int p = 0; p < 80; p++) begin
            int len;
            if ($urandom_range(0, 7) == 0)
                stim_q.push_back(mk($urandom_range(0, 1) ? T_TAIL : T_BODY, $urandom_range(0, 3), $urandom_range(0, 3)));
            len = $urandom_range(1, 5);
            if (len == 1) begin
                stim_q.push_back(mk(T_HT, $urandom_range(0, 3), $urandom_range(0, 3)));
            end else begin
                stim_q.push_back(mk(T_HEAD, $urandom_range(0, 3), $urandom_range(0, 3)));
                for (int b = 0; b < len - 2; b++) stim_q.push_back(mk(T_BODY, 0, 0));
                stim_q.push_back(mk(T_TAIL, 0, 0));
            end
        end
        run_stream(5000, 60, 70);
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_err_total", 64'(seen_err), 64'(exp_err));
`ifdef NOC_IU_PERF_EN
        check("rand_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_pkts));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
